// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared types and geometry for the frame-buffer arbiter: cell grid, RAM widths,
// FSM and grant-source encodings, and the RAM request payload.
package frame_buffer_arbiter_pkg;

  localparam int unsigned CELLS_X  = 160;
  localparam int unsigned CELLS_Y  = 120;
  localparam int unsigned FB_DEPTH = CELLS_X * CELLS_Y;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned WR_ROW_W = 7;
  localparam int unsigned WR_COL_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DISP = 2'd1,
    G_CLR  = 2'd2,
    G_WR   = 2'd3
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               we;
    logic [COLOR_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Cell (row, col) to linear frame-buffer address: row*160 + col via shift-add.
module fb_addr_calc
  import frame_buffer_arbiter_pkg::*;
(
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  output logic [ADDR_W-1:0]  o_addr
);

  assign o_addr = ADDR_W'(18'({i_row, 7'b0}) + 18'({i_row, 5'b0}) + 18'(i_col));

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates a single-port frame-buffer RAM between display scan-out, a
// clear-screen sequencer and a drawing writer; display always wins.
module frame_buffer_arbiter
  import frame_buffer_arbiter_pkg::*;
(
  input  logic               SynchClock,
  input  logic               Reset,
  input  logic               ActiveVideo,
  input  logic [9:0]         PixelRow,
  input  logic [9:0]         PixelCol,
  output logic               RedOut,
  output logic               GreenOut,
  output logic               BlueOut,
  output logic               PixelOn,
  input  logic               WrReq,
  input  logic [6:0]         WrRow,
  input  logic [7:0]         WrCol,
  input  logic [COLOR_W-1:0] WrData,
  output logic               WrAck,
  input  logic               ClearReq,
  input  logic [COLOR_W-1:0] ClearColor,
  output logic               Busy,
  output logic               ClearDone,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic               MemWe,
  output logic [COLOR_W-1:0] MemWdata,
  input  logic [COLOR_W-1:0] MemRdata
);

  fsm_state_t         r_state;
  fsm_state_t         w_state_nxt;
  grant_t             w_grant;
  mem_req_t           w_mem;

  logic [ADDR_W-1:0]  w_disp_addr;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic               w_disp_need;
  logic               w_wr_in_range;
  logic               w_clr_last;

  logic [ADDR_W-1:0]  r_last_addr;
  logic               r_last_valid;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [COLOR_W-1:0] r_clr_color;
  logic [COLOR_W-1:0] r_color;
  logic               r_fetch_d;
  logic               r_av_d1;
  logic               r_av_d2;
  logic               r_wr_ack;
  logic               r_busy;
  logic               r_clear_done;

  fb_addr_calc u_disp_addr (
    .i_row  (PixelRow),
    .i_col  (PixelCol),
    .o_addr (w_disp_addr)
  );

  fb_addr_calc u_wr_addr (
    .i_row  (COORD_W'(WrRow)),
    .i_col  (COORD_W'(WrCol)),
    .o_addr (w_wr_addr)
  );

  assign w_disp_need   = ActiveVideo && (!r_last_valid || (w_disp_addr != r_last_addr));
  assign w_wr_in_range = (WrRow < WR_ROW_W'(CELLS_Y)) && (WrCol < WR_COL_W'(CELLS_X));
  assign w_clr_last    = (r_clr_cnt == ADDR_W'(FB_DEPTH - 1));

  // State register
  always_ff @(posedge SynchClock) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the clear ends on the write to the last cell
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ClearReq) w_state_nxt = CLEAR;
      CLEAR:   if ((w_grant == G_CLR) && w_clr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slot grant and RAM request: display, then clear, then writer
  always_comb begin
    w_grant = G_NONE;
    w_mem   = '0;
    if (Reset) begin
      if (w_disp_need) begin
        w_grant    = G_DISP;
        w_mem.addr = w_disp_addr;
      end else if (r_state == CLEAR) begin
        w_grant     = G_CLR;
        w_mem.addr  = r_clr_cnt;
        w_mem.we    = 1'b1;
        w_mem.wdata = r_clr_color;
      end else if ((r_state == IDLE) && WrReq && !r_wr_ack) begin
        // Out-of-range requests are consumed without touching the RAM
        w_grant = G_WR;
        if (w_wr_in_range) begin
          w_mem.addr  = w_wr_addr;
          w_mem.we    = 1'b1;
          w_mem.wdata = WrData;
        end
      end
    end
  end

  assign MemAddr  = w_mem.addr;
  assign MemWe    = w_mem.we;
  assign MemWdata = w_mem.wdata;

  // Display fetch tracking and colour/pixel-enable pipeline
  always_ff @(posedge SynchClock) begin
    if (!Reset) begin
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
      r_fetch_d    <= 1'b0;
      r_color      <= '0;
      r_av_d1      <= 1'b0;
      r_av_d2      <= 1'b0;
    end else begin
      if (w_grant == G_DISP) begin
        r_last_addr  <= w_disp_addr;
        r_last_valid <= 1'b1;
      end else if (!ActiveVideo) begin
        r_last_valid <= 1'b0;
      end
      r_fetch_d <= (w_grant == G_DISP);
      if (r_fetch_d) r_color <= MemRdata;
      r_av_d1 <= ActiveVideo;
      r_av_d2 <= r_av_d1;
    end
  end

  // Writer handshake and clear sequencer bookkeeping
  always_ff @(posedge SynchClock) begin
    if (!Reset) begin
      r_wr_ack     <= 1'b0;
      r_clr_cnt    <= '0;
      r_clr_color  <= '0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_wr_ack <= (w_grant == G_WR);
      if ((r_state == IDLE) && ClearReq) begin
        r_clr_cnt   <= '0;
        r_clr_color <= ClearColor;
      end else if (w_grant == G_CLR) begin
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + ADDR_W'(1);
      end
      r_busy       <= (w_state_nxt == CLEAR);
      r_clear_done <= (w_grant == G_CLR) && w_clr_last;
    end
  end

  assign RedOut    = r_color[2];
  assign GreenOut  = r_color[1];
  assign BlueOut   = r_color[0];
  assign PixelOn   = r_av_d2;
  assign WrAck     = r_wr_ack;
  assign Busy      = r_busy;
  assign ClearDone = r_clear_done;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed scenarios plus a
// randomized run scored against a cell-level model and a behavioural RAM.
module tb_frame_buffer_arbiter;

  localparam int NCELL = 19200;

  logic       SynchClock = 1'b0;
  logic       Reset;
  logic       ActiveVideo;
  logic [9:0] PixelRow;
  logic [9:0] PixelCol;
  logic       RedOut, GreenOut, BlueOut, PixelOn;
  logic       WrReq;
  logic [6:0] WrRow;
  logic [7:0] WrCol;
  logic [2:0] WrData;
  logic       WrAck;
  logic       ClearReq;
  logic [2:0] ClearColor;
  logic       Busy, ClearDone;
  logic [14:0] MemAddr;
  logic        MemWe;
  logic [2:0]  MemWdata;
  logic [2:0]  MemRdata;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  mem [0:NCELL-1];
  logic        bd_we = 1'b0;
  logic [14:0] bd_addr = '0;
  logic [2:0]  bd_data = '0;

  logic [2:0]  exp_mem [0:NCELL-1];
  bit          written [0:NCELL-1];

  frame_buffer_arbiter dut (
    .SynchClock (SynchClock),
    .Reset      (Reset),
    .ActiveVideo(ActiveVideo),
    .PixelRow   (PixelRow),
    .PixelCol   (PixelCol),
    .RedOut     (RedOut),
    .GreenOut   (GreenOut),
    .BlueOut    (BlueOut),
    .PixelOn    (PixelOn),
    .WrReq      (WrReq),
    .WrRow      (WrRow),
    .WrCol      (WrCol),
    .WrData     (WrData),
    .WrAck      (WrAck),
    .ClearReq   (ClearReq),
    .ClearColor (ClearColor),
    .Busy       (Busy),
    .ClearDone  (ClearDone),
    .MemAddr    (MemAddr),
    .MemWe      (MemWe),
    .MemWdata   (MemWdata),
    .MemRdata   (MemRdata)
  );

  always #5 SynchClock = ~SynchClock;

  // Single-port RAM with one-cycle read latency and a bench backdoor
  always @(posedge SynchClock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MemWe && (MemAddr < 15'(NCELL))) mem[MemAddr] <= MemWdata;
    MemRdata <= mem[MemAddr];
  end

  task automatic step();
    @(posedge SynchClock);
    #1;
  endtask

  task automatic smp();
    @(negedge SynchClock);
  endtask

  task automatic test_reset();
    Reset = 1'b0; WrReq = 1'b1; WrRow = 7'd2; WrCol = 8'd5; WrData = 3'd7;
    repeat (3) begin
      step(); smp();
      checks++;
      if ({RedOut, GreenOut, BlueOut, PixelOn, WrAck, Busy, ClearDone, MemWe} !== 8'b0 ||
          MemAddr !== 15'd0 || MemWdata !== 3'd0) begin
        failures++;
        $display("FAIL reset_outputs: got rgb=%b%b%b pon=%b ack=%b busy=%b done=%b we=%b addr=%0d wd=%0d, want all 0",
                 RedOut, GreenOut, BlueOut, PixelOn, WrAck, Busy, ClearDone, MemWe, MemAddr, MemWdata);
      end
    end
    step(); Reset = 1'b1; WrReq = 1'b0;
  endtask

  task automatic test_display();
    logic [2:0] exp_c;
    int rd0 = 0, rd1 = 0;
    bd_we = 1'b1; bd_addr = 15'd160; bd_data = 3'b101; step();
    bd_addr = 15'd161; bd_data = 3'b010; step();
    bd_addr = 15'd162; bd_data = 3'b110; step();
    bd_we = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step(); ActiveVideo = 1'b1; PixelRow = 10'd1; PixelCol = 10'(t / 4);
      smp();
      if (!MemWe && MemAddr == 15'd160) rd0++;
      if (!MemWe && MemAddr == 15'd161) rd1++;
      exp_c = (t < 2) ? 3'b000 : (t < 6) ? 3'b101 : (t < 10) ? 3'b010 : 3'b110;
      checks++;
      if ({RedOut, GreenOut, BlueOut} !== exp_c || PixelOn !== (t >= 2)) begin
        failures++;
        $display("FAIL display_colour t=%0d: got rgb=%b%b%b pon=%b, want rgb=%b pon=%b",
                 t, RedOut, GreenOut, BlueOut, PixelOn, exp_c, (t >= 2));
      end
    end
    checks++;
    if (rd0 != 1 || rd1 != 1) begin
      failures++;
      $display("FAIL display_reads_per_cell: got cell0=%0d cell1=%0d, want 1 each", rd0, rd1);
    end
    step(); ActiveVideo = 1'b0; PixelRow = '0; PixelCol = '0;
  endtask

  task automatic test_write_blank();
    step(); ActiveVideo = 1'b0; WrReq = 1'b1; WrRow = 7'd2; WrCol = 8'd5; WrData = 3'b111;
    smp(); checks++;
    if (MemWe !== 1'b1 || MemAddr !== 15'd325 || MemWdata !== 3'b111 || WrAck !== 1'b0) begin
      failures++;
      $display("FAIL write_blank_grant: got we=%b addr=%0d wd=%b ack=%b, want we=1 addr=325 wd=111 ack=0",
               MemWe, MemAddr, MemWdata, WrAck);
    end
    step(); smp(); checks++;
    if (WrAck !== 1'b1 || MemWe !== 1'b0) begin
      failures++;
      $display("FAIL write_blank_ack: got ack=%b we=%b, want ack=1 we=0", WrAck, MemWe);
    end
    step(); WrCol = 8'd6; WrData = 3'b011; smp(); checks++;
    if (MemWe !== 1'b1 || MemAddr !== 15'd326 || WrAck !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_grant: got we=%b addr=%0d ack=%b, want we=1 addr=326 ack=0", MemWe, MemAddr, WrAck);
    end
    step(); smp(); checks++;
    if (WrAck !== 1'b1 || MemWe !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_ack: got ack=%b we=%b, want ack=1 we=0", WrAck, MemWe);
    end
    step(); WrReq = 1'b0; smp();
    checks++;
    if (mem[325] !== 3'b111 || mem[326] !== 3'b011) begin
      failures++;
      $display("FAIL write_blank_ram: got ram325=%b ram326=%b, want 111 and 011", mem[325], mem[326]);
    end
  endtask

  task automatic test_write_collision();
    step(); ActiveVideo = 1'b1; PixelRow = 10'd3; PixelCol = 10'd0;
    repeat (3) step();
    step(); PixelCol = 10'd1; WrReq = 1'b1; WrRow = 7'd4; WrCol = 8'd7; WrData = 3'b101;
    smp(); checks++;
    if (MemWe !== 1'b0 || MemAddr !== 15'd481) begin
      failures++;
      $display("FAIL collision_display_wins: got we=%b addr=%0d, want we=0 addr=481", MemWe, MemAddr);
    end
    step(); smp(); checks++;
    if (MemWe !== 1'b1 || MemAddr !== 15'd647 || WrAck !== 1'b0) begin
      failures++;
      $display("FAIL collision_write_next: got we=%b addr=%0d ack=%b, want we=1 addr=647 ack=0", MemWe, MemAddr, WrAck);
    end
    step(); smp(); checks++;
    if (WrAck !== 1'b1 || MemWe !== 1'b0) begin
      failures++;
      $display("FAIL collision_ack: got ack=%b we=%b, want ack=1 we=0", WrAck, MemWe);
    end
    step(); WrReq = 1'b0; ActiveVideo = 1'b0; PixelRow = '0; PixelCol = '0;
  endtask

  task automatic test_clear();
    int nxt = 0, bad = 0, early_ack = 0, cyc = 0;
    bit done_seen = 0;
    step(); ActiveVideo = 1'b0; ClearReq = 1'b1; ClearColor = 3'b001;
    step(); ClearReq = 1'b0; ClearColor = 3'b000; smp(); checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_busy_rise: got busy=%b, want 1", Busy);
    end
    while (!done_seen && cyc < 25000) begin
      if (MemWe && Busy) begin
        if (MemAddr !== 15'(nxt) || MemWdata !== 3'b001) bad++;
        nxt++;
      end
      if (WrAck) early_ack++;
      step(); cyc++;
      if (cyc == 10) begin WrReq = 1'b1; WrRow = 7'd5; WrCol = 8'd5; WrData = 3'b110; end
      if (cyc == 50) begin ClearReq = 1'b1; ClearColor = 3'b110; end else ClearReq = 1'b0;
      smp();
      if (ClearDone) done_seen = 1;
    end
    checks++;
    if (!done_seen || Busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_done: got done_seen=%0d busy=%b after %0d cycles, want done with busy=0", done_seen, Busy, cyc);
    end
    checks++;
    if (nxt != NCELL || bad != 0 || early_ack != 0) begin
      failures++;
      $display("FAIL clear_writes: got writes=%0d bad=%0d acks_during=%0d, want 19200 0 0", nxt, bad, early_ack);
    end
    checks++;
    if (MemWe !== 1'b1 || MemAddr !== 15'd805 || MemWdata !== 3'b110) begin
      failures++;
      $display("FAIL clear_stalled_write: got we=%b addr=%0d wd=%b, want we=1 addr=805 wd=110", MemWe, MemAddr, MemWdata);
    end
    step(); smp(); checks++;
    if (WrAck !== 1'b1 || ClearDone !== 1'b0) begin
      failures++;
      $display("FAIL clear_after_ack: got ack=%b done=%b, want ack=1 done=0", WrAck, ClearDone);
    end
    step(); WrReq = 1'b0; smp(); checks++;
    if (mem[805] !== 3'b110 || mem[0] !== 3'b001 || mem[NCELL-1] !== 3'b001) begin
      failures++;
      $display("FAIL clear_ram: got ram805=%b ram0=%b ramlast=%b, want 110 001 001", mem[805], mem[0], mem[NCELL-1]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0, cyc = 0, errs = 0;
    step(); ClearReq = 1'b1; ClearColor = 3'b010;
    step(); ClearReq = 1'b0; smp();
    while (n < 100 && cyc < 500) begin
      if (MemWe && Busy) n++;
      if (n < 100) begin step(); smp(); end
      cyc++;
    end
    checks++;
    if (n != 100) begin
      failures++;
      $display("FAIL midclear_progress: got %0d clear writes, want 100", n);
    end
    step(); Reset = 1'b0;
    step(); Reset = 1'b1; smp(); checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL midclear_abort: got busy=%b, want 0", Busy);
    end
    repeat (20) begin
      smp();
      if (ClearDone || Busy || MemWe) errs++;
      step();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL midclear_quiet: got %0d cycles with done/busy/we, want 0", errs);
    end
    WrReq = 1'b1; WrRow = 7'd10; WrCol = 8'd200; WrData = 3'b111;
    smp(); checks++;
    if (MemWe !== 1'b0 || WrAck !== 1'b0) begin
      failures++;
      $display("FAIL oor_no_write: got we=%b ack=%b, want we=0 ack=0", MemWe, WrAck);
    end
    step(); smp(); checks++;
    if (WrAck !== 1'b1 || MemWe !== 1'b0) begin
      failures++;
      $display("FAIL oor_ack: got ack=%b we=%b, want ack=1 we=0", WrAck, MemWe);
    end
    step(); WrReq = 1'b0;
  endtask

  task automatic test_random();
    int grp_left = 0, addr, req_t = 0, nwe = 0, n_inr = 0, rb_err = 0;
    bit m_valid = 0, col_known = 0, outst = 0, ack_prev = 0, need, av_h1 = 0, av_h2 = 0;
    int m_last = 0, pend_at = -1;
    logic [2:0] pend_val = '0, exp_col = '0;
    for (int t = 0; t < 3010; t++) begin
      step();
      if (grp_left == 0) begin
        grp_left = 4;
        ActiveVideo = (t < 3000) && ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) begin
          PixelRow = 10'($urandom_range(0, 119));
          PixelCol = 10'($urandom_range(0, 159));
        end
      end
      grp_left--;
      if (outst && ack_prev) outst = 0;
      ack_prev = 0;
      if (!outst && t < 3000 && $urandom_range(0, 2) == 0) begin
        outst = 1; req_t = t;
        WrRow = 7'($urandom_range(0, 127));
        WrCol = 8'($urandom_range(0, 255));
        WrData = 3'($urandom_range(0, 7));
      end
      WrReq = outst;
      smp();
      if (pend_at == t) begin exp_col = pend_val; col_known = 1; end
      if (col_known) begin
        checks++;
        if ({RedOut, GreenOut, BlueOut} !== exp_col) begin
          failures++;
          $display("FAIL rand_colour t=%0d: got %b%b%b, want %b", t, RedOut, GreenOut, BlueOut, exp_col);
        end
      end
      checks++;
      if (PixelOn !== av_h2) begin
        failures++;
        $display("FAIL rand_pixelon t=%0d: got %b, want %b", t, PixelOn, av_h2);
      end
      av_h2 = av_h1; av_h1 = ActiveVideo;
      addr = int'(PixelRow) * 160 + int'(PixelCol);
      need = ActiveVideo && (!m_valid || addr != m_last);
      if (need) begin
        checks++;
        if (MemWe !== 1'b0 || MemAddr !== 15'(addr)) begin
          failures++;
          $display("FAIL rand_fetch t=%0d: got we=%b addr=%0d, want we=0 addr=%0d", t, MemWe, MemAddr, addr);
        end
        m_valid = 1; m_last = addr; pend_val = mem[addr]; pend_at = t + 2;
      end else if (!ActiveVideo) begin
        m_valid = 0;
      end
      if (MemWe) nwe++;
      if (WrAck) begin
        checks++;
        if (!outst || t - req_t > 2) begin
          failures++;
          $display("FAIL rand_ack t=%0d: got ack with outstanding=%0d latency=%0d, want outstanding=1 latency<=2", t, outst, t - req_t);
        end
        if (WrRow < 7'd120 && WrCol < 8'd160) begin
          addr = int'(WrRow) * 160 + int'(WrCol);
          exp_mem[addr] = WrData; written[addr] = 1; n_inr++;
        end
        ack_prev = 1;
      end else if (outst && t - req_t > 2) begin
        checks++; failures++;
        $display("FAIL rand_ack_timeout t=%0d: got no ack after %0d cycles, want <=2", t, t - req_t);
        outst = 0;
      end
    end
    WrReq = 1'b0; ActiveVideo = 1'b0;
    step();
    for (int i = 0; i < NCELL; i++) if (written[i] && mem[i] !== exp_mem[i]) rb_err++;
    checks++;
    if (rb_err != 0 || nwe != n_inr) begin
      failures++;
      $display("FAIL rand_ram: got %0d bad cells, %0d writes, want 0 bad and %0d writes", rb_err, nwe, n_inr);
    end
  endtask

  initial begin
    Reset = 1'b0; ActiveVideo = 1'b0; PixelRow = '0; PixelCol = '0;
    WrReq = 1'b0; WrRow = '0; WrCol = '0; WrData = '0;
    ClearReq = 1'b0; ClearColor = '0;
    test_reset();
    test_display();
    test_write_blank();
    test_write_collision();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
